// File: rtl/fpnew_norm_roundprep.sv
// rtl/fpnew_norm_roundprep.sv - iterative mantissa normalizer producing round/sticky bits for a rounder.
// Optional macro FPNEW_NORM_ROUNDPREP_LZC_EN: full leading-zero count, single-step normalization.
module fpnew_norm_roundprep #(
  parameter int InWidth   = 48,
  parameter int PrecBits  = 24,
  parameter int ExpWidth  = 10,
  parameter int ShiftStep = 4
) (
  input  logic                clk_i,
  input  logic                rst_i,
  input  logic [InWidth-1:0]  mant_i,
  input  logic [ExpWidth-1:0] exp_i,
  input  logic                sign_i,
  input  logic                sticky_i,
  input  logic                in_valid_i,
  output logic                in_ready_o,
  output logic [PrecBits-1:0] mant_o,
  output logic [ExpWidth-1:0] exp_o,
  output logic                sign_o,
  output logic [1:0]          round_sticky_bits_o,
  output logic                out_valid_o,
  input  logic                out_ready_i
);

  localparam int LzW = $clog2(InWidth + 1);
  localparam int LW  = ((LzW > ExpWidth) ? LzW : ExpWidth) + 1;

  typedef enum logic [1:0] {IDLE, SHIFT, DONE} state_t;

  state_t              r_state;
  logic [InWidth-1:0]  r_mant;
  logic [ExpWidth-1:0] r_exp;
  logic                r_sign;
  logic                r_sticky;

  logic [LzW-1:0]      w_lz;
  logic                w_found;
  logic [ExpWidth-1:0] w_explim;
  logic [LW-1:0]       w_lz_x;
  logic [LW-1:0]       w_explim_x;
  logic [LW-1:0]       w_lim;
  logic [LW-1:0]       w_s;
  logic                w_done;
  logic                w_mant_zero;

`ifdef FPNEW_NORM_ROUNDPREP_LZC_EN
  always_comb begin
    w_lz    = '0;
    w_found = 1'b0;
    for (int i = InWidth - 1; i >= 0; i--) begin
      if (!w_found) begin
        if (r_mant[i]) w_found = 1'b1;
        else           w_lz = w_lz + LzW'(1);
      end
    end
  end
`else
  // Only the top ShiftStep+1 bits matter: enough to size this step and tell if it is the last one.
  always_comb begin
    w_lz    = '0;
    w_found = 1'b0;
    for (int i = InWidth - 1; i >= InWidth - 1 - ShiftStep; i--) begin
      if (!w_found) begin
        if (r_mant[i]) w_found = 1'b1;
        else           w_lz = w_lz + LzW'(1);
      end
    end
  end
`endif

  assign w_mant_zero = ~|r_mant;
  assign w_explim    = (r_exp == '0) ? '0 : r_exp - ExpWidth'(1);
  assign w_lz_x      = LW'(w_lz);
  assign w_explim_x  = LW'(w_explim);
  assign w_lim       = w_mant_zero ? '0 : ((w_lz_x < w_explim_x) ? w_lz_x : w_explim_x);

`ifdef FPNEW_NORM_ROUNDPREP_LZC_EN
  assign w_s    = w_lim;
  assign w_done = 1'b1;
`else
  assign w_s    = (w_lim < LW'(ShiftStep)) ? w_lim : LW'(ShiftStep);
  assign w_done = (w_lim <= LW'(ShiftStep));
`endif

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      r_state  <= IDLE;
      r_mant   <= '0;
      r_exp    <= '0;
      r_sign   <= 1'b0;
      r_sticky <= 1'b0;
    end else begin
      case (r_state)
        IDLE: begin
          if (in_valid_i) begin
            r_mant   <= mant_i;
            r_exp    <= exp_i;
            r_sign   <= sign_i;
            r_sticky <= sticky_i;
            r_state  <= SHIFT;
          end
        end
        SHIFT: begin
          r_mant <= r_mant << w_s;
          r_exp  <= r_exp - ExpWidth'(w_s);
          if (w_done) r_state <= DONE;
        end
        DONE: begin
          if (out_ready_i) r_state <= IDLE;
        end
        default: r_state <= IDLE;
      endcase
    end
  end

  assign in_ready_o  = (r_state == IDLE);
  assign out_valid_o = (r_state == DONE);
  assign mant_o      = r_mant[InWidth-1 -: PrecBits];
  // A cleared hidden bit means the exponent floor was hit: report denormal/zero.
  assign exp_o       = r_mant[InWidth-1] ? r_exp : '0;
  assign sign_o      = r_sign;
  assign round_sticky_bits_o = {r_mant[InWidth-PrecBits-1],
                                (|r_mant[InWidth-PrecBits-2:0]) | r_sticky};

endmodule

// File: tb/tb_fpnew_norm_roundprep.sv
// tb/tb_fpnew_norm_roundprep.sv - directed self-checking bench for fpnew_norm_roundprep.
module tb_fpnew_norm_roundprep;

  logic        clk_i = 1'b0;
  logic        rst_i = 1'b1;
  logic [47:0] mant_i = '0;
  logic [9:0]  exp_i = '0;
  logic        sign_i = 1'b0;
  logic        sticky_i = 1'b0;
  logic        in_valid_i = 1'b0;
  logic        in_ready_o;
  logic [23:0] mant_o;
  logic [9:0]  exp_o;
  logic        sign_o;
  logic [1:0]  round_sticky_bits_o;
  logic        out_valid_o;
  logic        out_ready_i = 1'b0;

  int n_vec = 0;
  int n_err = 0;

  fpnew_norm_roundprep dut (
    .clk_i(clk_i), .rst_i(rst_i), .mant_i(mant_i), .exp_i(exp_i), .sign_i(sign_i),
    .sticky_i(sticky_i), .in_valid_i(in_valid_i), .in_ready_o(in_ready_o),
    .mant_o(mant_o), .exp_o(exp_o), .sign_o(sign_o),
    .round_sticky_bits_o(round_sticky_bits_o), .out_valid_o(out_valid_o),
    .out_ready_i(out_ready_i)
  );

  always #5 clk_i = ~clk_i;

`ifdef FPNEW_NORM_ROUNDPREP_LZC_EN
  localparam bit LZC = 1'b1;
`else
  localparam bit LZC = 1'b0;
`endif

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] expv);
    n_vec++;
    assert (obs === expv) else begin
      n_err++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, expv);
    end
  endtask

  task automatic run(input string tag, input logic [47:0] m, input logic [9:0] e,
                     input logic s, input logic st, input int lat_exp, input int hold,
                     input logic [23:0] m_exp, input logic [9:0] e_exp, input logic [1:0] rs_exp);
    int lat;
    logic [23:0] m0;
    @(negedge clk_i);
    mant_i = m; exp_i = e; sign_i = s; sticky_i = st; in_valid_i = 1'b1;
    @(posedge clk_i); #1;
    in_valid_i = 1'b0;
    mant_i = ~m;
    chk({tag, "_busy"}, {63'd0, in_ready_o}, 64'd0);
    lat = 0;
    while (!out_valid_o && lat < 40) begin
      @(posedge clk_i); #1;
      lat++;
    end
    chk({tag, "_lat"}, 64'(lat), 64'(lat_exp));
    chk({tag, "_mant"}, {40'd0, mant_o}, {40'd0, m_exp});
    chk({tag, "_exp"}, {54'd0, exp_o}, {54'd0, e_exp});
    chk({tag, "_rs"}, {62'd0, round_sticky_bits_o}, {62'd0, rs_exp});
    chk({tag, "_sign"}, {63'd0, sign_o}, {63'd0, s});
    m0 = mant_o;
    for (int k = 0; k < hold; k++) begin
      @(posedge clk_i); #1;
      chk({tag, "_hold"}, {38'd0, out_valid_o, in_ready_o, mant_o},
          {38'd0, 1'b1, 1'b0, m0});
    end
    // Consume with a new request already pending: it must not be taken on this edge.
    in_valid_i = 1'b1;
    out_ready_i = 1'b1;
    @(posedge clk_i); #1;
    out_ready_i = 1'b0;
    chk({tag, "_consume"}, {62'd0, out_valid_o, in_ready_o}, 64'd1);
    in_valid_i = 1'b0;
  endtask

  initial begin
    repeat (2) @(posedge clk_i);
    #1;
    rst_i = 1'b0;
    chk("reset_hs", {62'd0, out_valid_o, in_ready_o}, 64'd1);
    chk("reset_data", {24'd0, mant_o, exp_o, sign_o, round_sticky_bits_o, 3'd0}, 64'd0);

    run("v_norm", 48'h8000_0000_0001, 10'd100, 1'b1, 1'b0, 1, 0, 24'h800000, 10'd100, 2'b01);
    run("v_lz19", 48'h0000_1000_0000, 10'd100, 1'b0, 1'b0, LZC ? 1 : 5, 0, 24'h800000, 10'd81, 2'b00);
    run("v_expcap", 48'h0000_1000_0000, 10'd5, 1'b0, 1'b0, 1, 0, 24'h000100, 10'd0, 2'b00);
    run("v_zero", 48'h0, 10'd50, 1'b0, 1'b1, 1, 0, 24'h000000, 10'd0, 2'b01);
    run("v_lz8", 48'h00FF_FFFF_FFFF, 10'd20, 1'b1, 1'b0, LZC ? 1 : 2, 0, 24'hFFFFFF, 10'd12, 2'b11);
    run("v_exp1", 48'h0800_0000_0000, 10'd1, 1'b0, 1'b0, 1, 0, 24'h080000, 10'd0, 2'b00);
    run("v_exp0", 48'h0800_0000_0000, 10'd0, 1'b0, 1'b1, 1, 0, 24'h080000, 10'd0, 2'b01);
    run("v_bp", 48'h8000_0000_0001, 10'd100, 1'b0, 1'b0, 1, 3, 24'h800000, 10'd100, 2'b01);

    // Reset while the operation is still in flight.
    @(negedge clk_i);
    mant_i = 48'h0000_1000_0000; exp_i = 10'd100; sign_i = 1'b1; in_valid_i = 1'b1;
    @(posedge clk_i); #1;
    in_valid_i = 1'b0;
    rst_i = 1'b1;
    out_ready_i = 1'b1;
    @(posedge clk_i); #1;
    rst_i = 1'b0;
    out_ready_i = 1'b0;
    chk("rst_hs", {62'd0, out_valid_o, in_ready_o}, 64'd1);
    chk("rst_data", {24'd0, mant_o, exp_o, sign_o, round_sticky_bits_o, 3'd0}, 64'd0);
    for (int k = 0; k < 8; k++) begin
      @(posedge clk_i); #1;
      chk("rst_nostale", {63'd0, out_valid_o}, 64'd0);
    end

    run("v_after_rst", 48'h0000_1000_0000, 10'd100, 1'b0, 1'b0, LZC ? 1 : 5, 0, 24'h800000, 10'd81, 2'b00);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
